// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer feeding the IF/ID stage.
// Optional build macro PC_MISALIGN_EN adds a pc_misalign pulse for misaligned redirect targets.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4
`ifdef PC_MISALIGN_EN
   ,
   output logic        pc_misalign
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_OUT  = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_tgt;
   logic        redir_taken;

   assign pc_plus4     = pc_q + 32'd4;
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      if_pc4_d    = if_pc4_q;
      redir_taken = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end

         S_REQ: begin
            if (redirect_valid) begin
               pc_d        = redirect_tgt;
               redir_taken = 1'b1;
               // A granted request now carries the stale address; its response must be dropped.
               state_d     = imem_gnt ? S_DROP : S_REQ;
            end else if (imem_gnt) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect_valid) begin
               pc_d        = redirect_tgt;
               redir_taken = 1'b1;
               state_d     = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               if_instr_d = imem_rdata;
               if_pc_d    = pc_q;
               if_pc4_d   = pc_plus4;
               if_valid_d = 1'b1;
               state_d    = S_OUT;
            end
         end

         S_DROP: begin
            if (redirect_valid) begin
               pc_d        = redirect_tgt;
               redir_taken = 1'b1;
            end
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end

         S_OUT: begin
            // Redirect wins over acceptance and squashes the held instruction.
            if (redirect_valid) begin
               pc_d        = redirect_tgt;
               redir_taken = 1'b1;
               if_valid_d  = 1'b0;
               state_d     = S_REQ;
            end else if (if_ready) begin
               pc_d       = pc_plus4;
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end

         default: begin
            state_d    = S_IDLE;
            if_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC_ALIGNED;
         if_valid_q <= 1'b0;
         if_instr_q <= 32'd0;
         if_pc_q    <= 32'd0;
         if_pc4_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_pc4    = if_pc4_q;

`ifdef PC_MISALIGN_EN
   logic pc_misalign_q, pc_misalign_d;

   assign pc_misalign_d = redir_taken && (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_misalign_q <= 1'b0;
      end else begin
         pc_misalign_q <= pc_misalign_d;
      end
   end

   assign pc_misalign = pc_misalign_q;
`else
   // Low redirect bits are dropped silently in this build.
   logic unused_redirect;
   assign unused_redirect = ^{redirect_pc[1:0], redir_taken};
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the MIPS core, upstream of the IF/ID register.
- Holds the architectural PC and issues one word fetch at a time to instruction memory.
- Applies branch/jump redirects and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Computes pc+4 internally and registers it alongside pc.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; always equals pc
imem_gnt  input  1  memory accepts the request this cycle
imem_rvalid  input  1  read data valid (one pulse per granted request)
imem_rdata  input  32  instruction word
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
if_valid  output  1  fetched instruction available to decode
if_ready  input  1  decode accepts the instruction this cycle
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr
if_pc4  output  32  if_pc + 4

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: pc=RESET_PC, state=S_IDLE, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, imem_req=0. Reset applies immediately, mid-fetch included. Outstanding responses are forgotten.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT, S_DROP.
- imem_req = (state==S_REQ). imem_addr = pc in all states.
- S_IDLE: go to S_REQ the next cycle. imem_rvalid is ignored.
- S_REQ:
  - On imem_gnt, go to S_WAIT.
  - On redirect_valid without gnt: pc<=redirect_pc, stay in S_REQ.
  - On redirect_valid with gnt: pc<=redirect_pc, go to S_DROP. The response belongs to the old pc.
  - imem_rvalid is ignored.
- S_WAIT:
  - On imem_rvalid: if_instr<=imem_rdata, if_pc<=pc, if_pc4<=pc+4, if_valid<=1, go to S_OUT.
  - On redirect_valid with no rvalid: pc<=redirect_pc, go to S_DROP.
  - On redirect_valid with rvalid in the same cycle: discard the data, pc<=redirect_pc, go to S_REQ.
- S_DROP: wait for imem_rvalid, discard the data, go to S_REQ. A redirect here updates pc and stays in S_DROP.
- S_OUT:
  - if_valid=1. Outputs are held stable until accepted.
  - On if_ready: if_valid<=0, pc<=pc+4, go to S_REQ.
  - redirect_valid has priority over if_ready: if_valid<=0, pc<=redirect_pc, go to S_REQ. The held instruction is squashed.
- Throughput: at most one instruction per 3 cycles with 1-cycle memory (REQ, WAIT, OUT). No prefetch.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Alignment: pc[1:0] is always 0. A redirect loads {redirect_pc[31:2],2'b00}.
- Only one request is ever outstanding. imem_gnt outside S_REQ is ignored.

Optional Feature:
- Macro: PC_MISALIGN_EN.
- Defined:
  - Extra output pc_misalign (1 bit, reset 0).
  - Pulses high for exactly one cycle, the cycle after a redirect is accepted with redirect_pc[1:0]!=0.
  - pc is still loaded with the low bits cleared.
- Not defined:
  - No pc_misalign port.
  - Low bits are silently cleared.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt with rdata=32'h2008_0005, if_ready=1 -> first imem_addr=32'h0000_3000; if_valid with if_pc=32'h0000_3000, if_pc4=32'h0000_3004, if_instr=32'h2008_0005; next imem_addr=32'h0000_3004.
- if_ready=0 for 5 cycles in S_OUT -> if_valid and if_instr/if_pc/if_pc4 held constant; imem_req stays 0.
- redirect_valid to 32'h0000_3040 while in S_WAIT, rvalid 2 cycles later -> that data never reaches if_valid; next request imem_addr=32'h0000_3040.
- redirect_valid together with if_ready in S_OUT, target 32'h0000_3100 -> next fetch at 32'h0000_3100, not pc+4.
- Redirect to 32'hFFFF_FFFC, fetch and accept -> if_pc4=32'h0000_0000; next imem_addr=32'h0000_0000.
- Redirect to 32'h0000_3102 (with PC_MISALIGN_EN) -> imem_addr=32'h0000_3100; pc_misalign high one cycle. Assert rst mid-S_WAIT -> if_valid=0 and imem_req=0 immediately; fetch restarts at RESET_PC.
